// File: rtl/fir_xifu_pkg.sv
// Shared types and defaults for the FIR XIFU issue/commit controller.
package fir_xifu_pkg;

  localparam int unsigned NB_REGS_DEF  = 4;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned ID_WIDTH_DEF = 4;
  localparam int unsigned RW_DEF       = $clog2(NB_REGS_DEF);

  // XIFU register index and XIF instruction id as stored in the in-flight queue.
  typedef logic [RW_DEF-1:0]       reg_idx_t;
  typedef logic [ID_WIDTH_DEF-1:0] xif_id_t;

  // One in-flight instruction, oldest at the queue head.
  typedef struct packed {
    xif_id_t  id;
    reg_idx_t rd;
    logic     rd_we;
    logic     committed;
    logic     killed;
  } fir_xifu_ctrl_entry_t;

endpackage

// File: rtl/fir_xifu_scoreboard.sv
// Busy-bit scoreboard for the XIFU register file plus the issue hazard check.
// A register is busy from the push of its writer until its write-back
// (or until the writer is dropped by a kill).
module fir_xifu_scoreboard
  import fir_xifu_pkg::*;
#(
  parameter  int unsigned NB_REGS = NB_REGS_DEF,
  localparam int unsigned RW      = $clog2(NB_REGS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NB_REGS-1:0] set,
  input  logic [NB_REGS-1:0] clr,
  input  logic [1:0]         rs_use,
  input  logic [RW-1:0]      rs1,
  input  logic [RW-1:0]      rs2,
  input  logic               rd_we,
  input  logic [RW-1:0]      rd,
  output logic [NB_REGS-1:0] busy,
  output logic               hazard
);

  logic [NB_REGS-1:0] busy_q;

  // Busy flops: clears and sets never hit the same register in one cycle,
  // because the WAW check blocks a push onto a register that is still busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      // NOTE: state is updated with <= so every flop samples the pre-edge value.
      busy_q <= (busy_q & ~clr) | set;
    end
  end

  assign busy = busy_q;

  // RAW on either used source, or WAW on the destination.
  assign hazard = (rs_use[0] & busy_q[rs1])
                | (rs_use[1] & busy_q[rs2])
                | (rd_we     & busy_q[rd]);

endmodule

// File: rtl/fir_xifu_ctrl.sv
// In-order issue/commit controller for the FIR XIFU coprocessor.
// Accepted instructions wait in a circular queue until the core commits them;
// the head is then handed to EX, or dropped silently if it was killed.
// Queue entries use the package id/index widths, so NB_REGS and ID_WIDTH
// are expected to match the package defaults.
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter  int unsigned NB_REGS  = NB_REGS_DEF,
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  int unsigned ID_WIDTH = ID_WIDTH_DEF,
  localparam int unsigned RW       = $clog2(NB_REGS),
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  input  logic                issue_accept_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [1:0]          issue_rs_use_i,
  input  logic [RW-1:0]       issue_rs1_i,
  input  logic [RW-1:0]       issue_rs2_i,
  input  logic                issue_rd_we_i,
  input  logic [RW-1:0]       issue_rd_i,
  output logic                issue_ready_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                ex_valid_o,
  output logic [ID_WIDTH-1:0] ex_id_o,
  input  logic                ex_ready_i,
  input  logic                wb_valid_i,
  input  logic [RW-1:0]       wb_rd_i,
  output logic [NB_REGS-1:0]  busy_o,
  output logic [AW:0]         inflight_o
);

  fir_xifu_ctrl_entry_t queue_q [DEPTH];
  fir_xifu_ctrl_entry_t head;
  fir_xifu_ctrl_entry_t new_entry;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]        rd_ptr_q, wr_ptr_q;
  logic [AW-1:0]      rd_idx, wr_idx;
  logic [AW:0]        occupancy;
  logic               empty, full;
  logic [DEPTH-1:0]   live;
  logic [AW-1:0]      offset;

  logic               hazard;
  logic               push, pop_exec, pop_kill, pop;
  logic               commit_new;
  logic [NB_REGS-1:0] busy_set, busy_clr;

  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign wr_idx    = wr_ptr_q[AW-1:0];
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign empty     = (rd_ptr_q == wr_ptr_q);
  assign full      = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_idx == wr_idx);
  assign head      = queue_q[rd_idx];

  // Outputs depend on registered queue state plus the decoded issue fields.
  assign issue_ready_o = !full && !hazard;
  assign ex_valid_o    = !empty && head.committed && !head.killed;
  assign ex_id_o       = ID_WIDTH'(head.id);
  assign inflight_o    = occupancy;

  assign push     = issue_valid_i && issue_accept_i && issue_ready_o;
  assign pop_exec = ex_valid_o && ex_ready_i;
  assign pop_kill = !empty && head.killed;
  assign pop      = pop_exec || pop_kill;

  // Mark which slots hold in-flight entries: distance from the head below occupancy.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    live   = '0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset  = AW'(i) - rd_idx;
      live[i] = ({1'b0, offset} < occupancy);
    end
  end

  // Build the pushed entry; a commit for the same id in this cycle lands on it directly.
  always_comb begin
    commit_new          = commit_valid_i && (commit_id_i == issue_id_i);
    new_entry           = '0;
    new_entry.id        = xif_id_t'(issue_id_i);
    new_entry.rd        = reg_idx_t'(issue_rd_i);
    new_entry.rd_we     = issue_rd_we_i;
    new_entry.committed = commit_new && !commit_kill_i;
    new_entry.killed    = commit_new && commit_kill_i;
  end

  // Scoreboard set on push, clear on write-back or when a killed writer is dropped.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (push && issue_rd_we_i) busy_set[issue_rd_i] = 1'b1;
    if (wb_valid_i)            busy_clr[wb_rd_i]    = 1'b1;
    if (pop_kill && head.rd_we) busy_clr[head.rd]   = 1'b1;
  end

  // Queue storage and pointers; commits mark every live entry with a matching id.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      // NOTE: the storage is reset as well so ex_id_o reads 0 out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        queue_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live[i] && commit_valid_i && (queue_q[i].id == xif_id_t'(commit_id_i))) begin
          if (commit_kill_i) queue_q[i].killed    <= 1'b1;
          else               queue_q[i].committed <= 1'b1;
        end
      end
      // The write slot is never live here because push requires a non-full queue.
      if (push) begin
        queue_q[wr_idx] <= new_entry;
        wr_ptr_q        <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  fir_xifu_scoreboard #(
    .NB_REGS (NB_REGS)
  ) u_scoreboard (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .set    (busy_set),
    .clr    (busy_clr),
    .rs_use (issue_rs_use_i),
    .rs1    (issue_rs1_i),
    .rs2    (issue_rs2_i),
    .rd_we  (issue_rd_we_i),
    .rd     (issue_rd_i),
    .busy   (busy_o),
    .hazard (hazard)
  );

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Testbench for fir_xifu_ctrl: directed vector table, a mid-operation reset,
// then random traffic compared against a queue-based reference model.
module tb_fir_xifu_ctrl;

  localparam int NB_REGS  = 4;
  localparam int DEPTH    = 4;
  localparam int ID_WIDTH = 4;
  localparam int RW       = 2;

  logic                clk, rst_n;
  logic                issue_valid, issue_accept, issue_rd_we, issue_ready;
  logic [ID_WIDTH-1:0] issue_id, commit_id, ex_id;
  logic [1:0]          issue_rs_use;
  logic [RW-1:0]       issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic                commit_valid, commit_kill, ex_valid, ex_ready, wb_valid;
  logic [NB_REGS-1:0]  busy;
  logic [2:0]          inflight;

  int errors = 0;
  int checks = 0;

  fir_xifu_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_accept_i (issue_accept),
    .issue_id_i     (issue_id),
    .issue_rs_use_i (issue_rs_use),
    .issue_rs1_i    (issue_rs1),
    .issue_rs2_i    (issue_rs2),
    .issue_rd_we_i  (issue_rd_we),
    .issue_rd_i     (issue_rd),
    .issue_ready_o  (issue_ready),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .ex_valid_o     (ex_valid),
    .ex_id_o        (ex_id),
    .ex_ready_i     (ex_ready),
    .wb_valid_i     (wb_valid),
    .wb_rd_i        (wb_rd),
    .busy_o         (busy),
    .inflight_o     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of inputs plus the outputs expected while they are applied.
  typedef struct {
    logic       iv, ia;
    logic [3:0] id;
    logic [1:0] rsu, rs1, rs2;
    logic       we;
    logic [1:0] rd;
    logic       cv;
    logic [3:0] cid;
    logic       ck, exr, wbv;
    logic [1:0] wbrd;
    logic       e_rdy, e_exv;
    logic [3:0] e_exid;
    logic [3:0] e_busy;
    logic [2:0] e_infl;
  } vec_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] rd;
    bit         we, com, kil;
  } m_ent_t;

  vec_t       tv[$];
  m_ent_t     mq[$];
  logic [1:0] wbq[$];
  logic [3:0] mbusy;

  function automatic vec_t row(input int iv, ia, id, rsu, rs1, rs2, we, rd,
                               cv, cid, ck, exr, wbv, wbrd,
                               er, ev, eid, eb, ei);
    vec_t r;
    r.iv = 1'(iv);   r.ia = 1'(ia);   r.id = 4'(id);
    r.rsu = 2'(rsu); r.rs1 = 2'(rs1); r.rs2 = 2'(rs2);
    r.we = 1'(we);   r.rd = 2'(rd);
    r.cv = 1'(cv);   r.cid = 4'(cid); r.ck = 1'(ck);
    r.exr = 1'(exr); r.wbv = 1'(wbv); r.wbrd = 2'(wbrd);
    r.e_rdy = 1'(er); r.e_exv = 1'(ev); r.e_exid = 4'(eid);
    r.e_busy = 4'(eb); r.e_infl = 3'(ei);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid  = v.iv;  issue_accept = v.ia;  issue_id  = v.id;
    issue_rs_use = v.rsu; issue_rs1    = v.rs1; issue_rs2 = v.rs2;
    issue_rd_we  = v.we;  issue_rd     = v.rd;
    commit_valid = v.cv;  commit_id    = v.cid; commit_kill = v.ck;
    ex_ready     = v.exr; wb_valid     = v.wbv; wb_rd     = v.wbrd;
  endtask

  task automatic compare_outs(input string tag, input logic rdy, input logic exv,
                              input logic [3:0] exid, input bit exid_en,
                              input logic [3:0] bsy, input logic [2:0] infl);
    check({tag, ".ready"},    32'(issue_ready), 32'(rdy));
    check({tag, ".ex_valid"}, 32'(ex_valid),    32'(exv));
    if (exid_en) check({tag, ".ex_id"}, 32'(ex_id), 32'(exid));
    check({tag, ".busy"},     32'(busy),        32'(bsy));
    check({tag, ".inflight"}, 32'(inflight),    32'(infl));
  endtask

  // Reference model: ready from occupancy and hazards on the busy set.
  function automatic bit m_ready(input vec_t s);
    return (mq.size() < DEPTH)
        && !(s.rsu[0] && mbusy[s.rs1])
        && !(s.rsu[1] && mbusy[s.rs2])
        && !(s.we && mbusy[s.rd]);
  endfunction

  function automatic bit m_exv();
    return (mq.size() > 0) && mq[0].com && !mq[0].kil;
  endfunction

  // Reference model: apply one clock edge with the inputs that were held during it.
  task automatic model_step(input vec_t s, input bit rdy, input bit exv);
    m_ent_t     e;
    bit         kill_head, exec_head;
    logic [3:0] clr, set;
    clr = '0;
    set = '0;
    kill_head = (mq.size() > 0) && mq[0].kil;
    exec_head = exv && s.exr;
    if (s.wbv) begin
      clr[s.wbrd] = 1'b1;
      wbq.delete(0);
    end
    if (kill_head && mq[0].we) clr[mq[0].rd] = 1'b1;
    if (exec_head && mq[0].we) wbq.push_back(mq[0].rd);
    for (int i = 0; i < mq.size(); i++) begin
      if (s.cv && mq[i].id == s.cid) begin
        e = mq[i];
        if (s.ck) e.kil = 1'b1;
        else      e.com = 1'b1;
        mq[i] = e;
      end
    end
    if (kill_head || exec_head) mq.delete(0);
    if (s.iv && s.ia && rdy) begin
      e.id  = s.id;
      e.rd  = s.rd;
      e.we  = s.we;
      e.com = s.cv && !s.ck && (s.cid == s.id);
      e.kil = s.cv && s.ck && (s.cid == s.id);
      mq.push_back(e);
      if (s.we) set[s.rd] = 1'b1;
    end
    mbusy = (mbusy & ~clr) | set;
  endtask

  function automatic vec_t rand_stim();
    vec_t s;
    s = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.iv  = ($urandom_range(3) != 0);
    s.ia  = ($urandom_range(7) != 0);
    s.id  = 4'($urandom);
    s.rsu = 2'($urandom);
    s.rs1 = 2'($urandom);
    s.rs2 = 2'($urandom);
    s.we  = 1'($urandom);
    s.rd  = 2'($urandom);
    s.cv  = ($urandom_range(2) == 0);
    if (mq.size() > 0 && $urandom_range(3) != 0) s.cid = mq[$urandom_range(mq.size() - 1)].id;
    else                                         s.cid = 4'($urandom);
    s.ck  = ($urandom_range(4) == 0);
    s.exr = 1'($urandom);
    s.wbv = (wbq.size() > 0) && ($urandom_range(1) == 1);
    if (s.wbv) s.wbrd = wbq[0];
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t idle, s;
    bit   rdy, exv;
    idle = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //         iv ia id rsu r1 r2 we rd  cv cid ck exr wbv wbrd  rdy exv exid busy    infl
    // Basic flow
    tv.push_back(row(1, 1,  3, 0, 0, 0, 1, 1,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1,  3, 0, 0, 0, 0,  1, 0,  0, 'b0010, 1));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0,  1, 1,  3, 'b0010, 1));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1,  1, 0,  0, 'b0010, 0));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    // RAW stall on rs1 until write-back of r2
    tv.push_back(row(1, 1,  1, 0, 0, 0, 1, 2,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(1, 1,  2, 1, 2, 0, 1, 3,  0,  0, 0, 0, 0, 0,  0, 0,  0, 'b0100, 1));
    tv.push_back(row(1, 1,  2, 1, 2, 0, 1, 3,  1,  1, 0, 0, 0, 0,  0, 0,  0, 'b0100, 1));
    tv.push_back(row(1, 1,  2, 1, 2, 0, 1, 3,  0,  0, 0, 1, 0, 0,  0, 1,  1, 'b0100, 1));
    tv.push_back(row(1, 1,  2, 1, 2, 0, 1, 3,  0,  0, 0, 0, 1, 2,  0, 0,  0, 'b0100, 0));
    tv.push_back(row(1, 1,  2, 1, 2, 0, 1, 3,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1,  2, 0, 0, 0, 0,  1, 0,  0, 'b1000, 1));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0,  1, 1,  2, 'b1000, 1));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 3,  1, 0,  0, 'b1000, 0));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    // Kill of the head, later entries committed
    tv.push_back(row(1, 1,  4, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(1, 1,  5, 0, 0, 0, 1, 1,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0001, 1));
    tv.push_back(row(1, 1,  6, 0, 0, 0, 1, 2,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0011, 2));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1,  4, 1, 0, 0, 0,  1, 0,  0, 'b0111, 3));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1,  5, 0, 0, 0, 0,  1, 0,  0, 'b0111, 3));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1,  6, 0, 0, 0, 0,  1, 1,  5, 'b0110, 2));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0,  1, 1,  5, 'b0110, 2));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0,  1, 1,  6, 'b0110, 1));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 1,  1, 0,  0, 'b0110, 0));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 2,  1, 0,  0, 'b0100, 0));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    // Full queue, then one commit and pop reopens issue
    tv.push_back(row(1, 1,  8, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(1, 1,  9, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 1));
    tv.push_back(row(1, 1, 10, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 2));
    tv.push_back(row(1, 1, 11, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 3));
    tv.push_back(row(1, 1, 12, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 'b0000, 4));
    tv.push_back(row(1, 1, 12, 0, 0, 0, 0, 0,  1,  8, 0, 0, 0, 0,  0, 0,  0, 'b0000, 4));
    tv.push_back(row(1, 1, 12, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0,  0, 1,  8, 'b0000, 4));
    tv.push_back(row(0, 0, 12, 0, 0, 0, 0, 0,  1,  9, 0, 0, 0, 0,  1, 0,  0, 'b0000, 3));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1, 10, 0, 0, 0, 0,  1, 1,  9, 'b0000, 3));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1, 11, 0, 1, 0, 0,  1, 1,  9, 'b0000, 3));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0,  1, 1, 10, 'b0000, 2));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0,  1, 1, 11, 'b0000, 1));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    // Same-cycle push and commit of id 7; WAW and rs2 RAW blocked behind it
    tv.push_back(row(1, 1,  7, 0, 0, 0, 1, 3,  1,  7, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(1, 1,  8, 0, 0, 0, 1, 3,  0,  0, 0, 0, 0, 0,  0, 1,  7, 'b1000, 1));
    tv.push_back(row(1, 1,  8, 2, 0, 3, 0, 0,  0,  0, 0, 1, 0, 0,  0, 1,  7, 'b1000, 1));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 1, 3,  1, 0,  0, 'b1000, 0));
    // Commit of an absent id, then an issue with accept low: no state change
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  1, 15, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(1, 0,  9, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));
    tv.push_back(row(0, 0,  0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0,  0, 'b0000, 0));

    // Reset state
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_outs("reset", 1'b1, 1'b0, 4'd0, 1'b1, 4'b0000, 3'd0);

    // Directed vectors
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      compare_outs($sformatf("row%0d", i), tv[i].e_rdy, tv[i].e_exv, tv[i].e_exid,
                   tv[i].e_exv, tv[i].e_busy, tv[i].e_infl);
    end

    // Asynchronous reset with three entries in flight
    @(negedge clk); drive(row(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(row(1, 1, 2, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(row(1, 1, 3, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(idle);
    #1;
    compare_outs("pre_reset", 1'b1, 1'b1, 4'd1, 1'b1, 4'b0111, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    compare_outs("async_reset", 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    wbq.delete();
    mbusy = '0;

    // Random traffic against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s = rand_stim();
      @(negedge clk);
      drive(s);
      #1;
      rdy = m_ready(s);
      exv = m_exv();
      compare_outs($sformatf("rnd%0d", cyc), rdy, exv,
                   (mq.size() > 0) ? mq[0].id : 4'd0, mq.size() > 0,
                   mbusy, 3'(mq.size()));
      @(posedge clk);
      model_step(s, rdy, exv);
    end

    @(negedge clk);
    drive(idle);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
